// File: rtl/prg_dma_loader.sv
// PRG DMA loader: halts the C64 CPU and writes a PRG image from ROM into RAM, one byte per phi2 period.
// Optional macro PRG_DMA_LOADER_BASIC_PATCH_EN adds a PATCH state that writes the program end pointer to $002D/$002E.
`timescale 1ns/1ps
module prg_dma_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic        BA,
  input  logic        start,
  input  logic [15:0] img_len,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        DMA,
  output logic [15:0] Ai,
  output logic [7:0]  Di,
  output logic        RW,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
  typedef enum logic [2:0] {IDLE = 3'd0, HDR_LO = 3'd1, HDR_HI = 3'd2, ARB = 3'd3,
                            XFER = 3'd4, PATCH = 3'd5, FINISH = 3'd6} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, HDR_LO = 3'd1, HDR_HI = 3'd2, ARB = 3'd3,
                            XFER = 3'd4, FINISH = 3'd6} state_t;
`endif

  state_t      r_state;
  state_t      w_nextState;
  logic        r_phi2Q;
  logic        w_boundary;
  logic [15:0] r_remaining;
  logic [15:0] r_wrAddr;
  logic [15:0] r_srcAddr;
  logic [1:0]  r_fetch;
  logic [7:0]  r_byte;
  logic        r_byteValid;
  logic [1:0]  r_arbCnt;
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
  logic [1:0]  r_patchStep;
`endif
  logic        r_dma;
  logic [15:0] r_ai;
  logic [7:0]  r_di;
  logic        r_rw;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  assign w_boundary = r_phi2Q & ~phi2;

  assign src_addr = r_srcAddr;
  assign DMA      = r_dma;
  assign Ai       = r_ai;
  assign Di       = r_di;
  assign RW       = r_rw;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:   if (start && (img_len >= 16'd3)) w_nextState = HDR_LO;
      HDR_LO: if (r_fetch[1]) w_nextState = HDR_HI;
      HDR_HI: if (r_fetch[1]) w_nextState = ARB;
      ARB:    if (w_boundary && BA && (r_arbCnt == 2'd2)) w_nextState = XFER;
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
      XFER:   if (w_boundary && (r_remaining == 16'd0)) w_nextState = PATCH;
      PATCH:  if (w_boundary && (r_patchStep == 2'd2)) w_nextState = FINISH;
`else
      XFER:   if (w_boundary && (r_remaining == 16'd0)) w_nextState = FINISH;
`endif
      FINISH: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // r_fetch is a two-stage tag following each ROM read: bit 1 set means src_data holds the requested byte now.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phi2Q     <= 1'b0;
      r_remaining <= 16'd0;
      r_wrAddr    <= 16'd0;
      r_srcAddr   <= 16'd0;
      r_fetch     <= 2'b00;
      r_byte      <= 8'd0;
      r_byteValid <= 1'b0;
      r_arbCnt    <= 2'd0;
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
      r_patchStep <= 2'd0;
`endif
      r_dma       <= 1'b0;
      r_ai        <= 16'd0;
      r_di        <= 8'd0;
      r_rw        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_phi2Q <= phi2;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_fetch <= {r_fetch[0], 1'b0};
      if (r_fetch[1] && ((r_state == ARB) || (r_state == XFER))) begin
        r_byte      <= src_data;
        r_byteValid <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            if (img_len < 16'd3) begin
              r_error <= 1'b1;
            end else begin
              r_busy      <= 1'b1;
              r_remaining <= img_len - 16'd2;
              r_srcAddr   <= 16'd0;
              r_fetch[0]  <= 1'b1;
              r_byteValid <= 1'b0;
              r_arbCnt    <= 2'd0;
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
              r_patchStep <= 2'd0;
`endif
            end
          end
        end
        HDR_LO: begin
          if (r_fetch[1]) begin
            r_wrAddr[7:0] <= src_data;
            r_srcAddr     <= 16'd1;
            r_fetch[0]    <= 1'b1;
          end
        end
        HDR_HI: begin
          if (r_fetch[1]) begin
            r_wrAddr[15:8] <= src_data;
            r_srcAddr      <= 16'd2;
            r_fetch[0]     <= 1'b1;
            r_dma          <= 1'b1;
          end
        end
        ARB: begin
          if (w_boundary) begin
            if (BA) r_arbCnt <= (r_arbCnt == 2'd2) ? 2'd0 : r_arbCnt + 2'd1;
            else    r_arbCnt <= 2'd0;
          end
        end
        XFER: begin
          // r_wrAddr doubles as load_addr+k; after the last byte it equals the program end address.
          if (w_boundary) begin
            if ((r_remaining != 16'd0) && BA && r_byteValid) begin
              r_ai        <= r_wrAddr;
              r_di        <= r_byte;
              r_rw        <= 1'b0;
              r_wrAddr    <= r_wrAddr + 16'd1;
              r_remaining <= r_remaining - 16'd1;
              r_byteValid <= 1'b0;
              if (r_remaining > 16'd1) begin
                r_srcAddr  <= r_srcAddr + 16'd1;
                r_fetch[0] <= 1'b1;
              end
            end else begin
              r_rw <= 1'b1;
            end
          end
        end
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
        PATCH: begin
          if (w_boundary) begin
            if ((r_patchStep != 2'd2) && BA) begin
              r_ai        <= r_patchStep[0] ? 16'h002E : 16'h002D;
              r_di        <= r_patchStep[0] ? r_wrAddr[15:8] : r_wrAddr[7:0];
              r_rw        <= 1'b0;
              r_patchStep <= r_patchStep + 2'd1;
            end else begin
              r_rw <= 1'b1;
            end
          end
        end
`endif
        FINISH: begin
          r_dma  <= 1'b0;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Self-checking bench for prg_dma_loader: a bus monitor pops expected writes from a scoreboard queue once per phi2 period.
`timescale 1ns/1ps
module tb_prg_dma_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        phi2 = 1'b0;
  logic        BA = 1'b1;
  logic        start = 1'b0;
  logic [15:0] img_len = 16'd0;
  logic [15:0] src_addr;
  logic [7:0]  src_data;
  logic        DMA;
  logic [15:0] Ai;
  logic [7:0]  Di;
  logic        RW;
  logic        busy;
  logic        done;
  logic        error;

  logic [7:0]  rom [0:15];
  logic [23:0] expQ [$];
  int          wrPeriods [$];
  logic [23:0] monExp;
  int          checks = 0;
  int          failures = 0;
  int          wrCount = 0;
  int          periodIdx = 0;
  int          doneCount = 0;
  int          errorCount = 0;
  bit          dmaSeen = 1'b0;

  prg_dma_loader dut (
    .clk(clk), .reset(reset), .phi2(phi2), .BA(BA), .start(start), .img_len(img_len),
    .src_addr(src_addr), .src_data(src_data), .DMA(DMA), .Ai(Ai), .Di(Di), .RW(RW),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Image ROM with one clk of read latency.
  always @(posedge clk) src_data <= rom[src_addr[3:0]];

  initial forever begin
    repeat (4) @(posedge clk);
    #1 phi2 = ~phi2;
  end

  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
    if (error === 1'b1) errorCount++;
    if (DMA === 1'b1) dmaSeen = 1'b1;
  end

  // One bus sample per phi2 period, taken mid-cycle after the DUT has reacted to the falling edge.
  initial forever begin
    @(negedge phi2);
    repeat (3) @(negedge clk);
    periodIdx++;
    if (RW === 1'b0) begin
      wrCount++;
      wrPeriods.push_back(periodIdx);
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: got Ai=%h Di=%h, no write expected", Ai, Di);
      end else begin
        monExp = expQ.pop_front();
        if ({Ai, Di} !== monExp) begin
          failures++;
          $display("[TB] FAIL bus_write: got Ai=%h Di=%h, expected Ai=%h Di=%h",
                   Ai, Di, monExp[23:8], monExp[7:0]);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic setImage(input logic [7:0] b0, b1, b2, b3, b4);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3; rom[4] = b4;
  endtask

  task automatic pulseStart(input logic [15:0] len);
    @(posedge clk);
    #1 start = 1'b1; img_len = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitWrites(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (wrCount >= target) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic waitDone(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (doneCount > d0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (DMA !== 1'b0)      begin failures++; $display("[TB] FAIL reset_dma: got %b expected 0", DMA); end
    checks++; if (Ai !== 16'h0000)   begin failures++; $display("[TB] FAIL reset_ai: got %h expected 0000", Ai); end
    checks++; if (Di !== 8'h00)      begin failures++; $display("[TB] FAIL reset_di: got %h expected 00", Di); end
    checks++; if (RW !== 1'b1)       begin failures++; $display("[TB] FAIL reset_rw: got %b expected 1", RW); end
    checks++; if (src_addr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_src_addr: got %h expected 0000", src_addr); end
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, error}); end
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_nominal();
    int d0, w0, e0;
    bit ok;
    setImage(8'h01, 8'h08, 8'hAA, 8'hBB, 8'hCC);
    expQ.push_back({16'h0801, 8'hAA});
    expQ.push_back({16'h0802, 8'hBB});
    expQ.push_back({16'h0803, 8'hCC});
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
    expQ.push_back({16'h002D, 8'h04});
    expQ.push_back({16'h002E, 8'h08});
`endif
    wrPeriods.delete();
    d0 = doneCount; w0 = wrCount; e0 = errorCount;
    pulseStart(16'd5);
    waitWrites(w0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL nominal_first_write: got timeout expected write"); end
    pulseStart(16'd2);
    waitDone(d0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL nominal_done: got timeout expected done"); end
    checks++; if (doneCount - d0 != 1) begin failures++; $display("[TB] FAIL nominal_done_pulses: got %0d expected 1", doneCount - d0); end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL nominal_missing_writes: got %0d left expected 0", expQ.size()); end
    checks++; if ({DMA, busy} !== 2'b00) begin failures++; $display("[TB] FAIL nominal_end_state: got DMA,busy=%b expected 00", {DMA, busy}); end
    checks++; if (errorCount != e0) begin failures++; $display("[TB] FAIL start_while_busy: got %0d error pulses expected 0", errorCount - e0); end
    checks++;
    if (wrPeriods.size() < 3 || wrPeriods[1] - wrPeriods[0] != 1 || wrPeriods[2] - wrPeriods[1] != 1) begin
      failures++; $display("[TB] FAIL nominal_spacing: got %0d writes not on consecutive periods, expected 3 consecutive", wrPeriods.size());
    end
    expQ.delete();
  endtask

  task automatic test_ba_low();
    int d0, w0;
    bit ok;
    setImage(8'h01, 8'h08, 8'hAA, 8'hBB, 8'hCC);
    expQ.push_back({16'h0801, 8'hAA});
    expQ.push_back({16'h0802, 8'hBB});
    expQ.push_back({16'h0803, 8'hCC});
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
    expQ.push_back({16'h002D, 8'h04});
    expQ.push_back({16'h002E, 8'h08});
`endif
    wrPeriods.delete();
    d0 = doneCount; w0 = wrCount;
    pulseStart(16'd5);
    waitWrites(w0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL ba_first_write: got timeout expected write"); end
    BA = 1'b0;
    repeat (2) @(negedge phi2);
    @(posedge clk);
    #1 BA = 1'b1;
    waitDone(d0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL ba_done: got timeout expected done"); end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL ba_missing_writes: got %0d left expected 0", expQ.size()); end
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
    checks++; if (wrCount - w0 != 5) begin failures++; $display("[TB] FAIL ba_write_count: got %0d expected 5", wrCount - w0); end
`else
    checks++; if (wrCount - w0 != 3) begin failures++; $display("[TB] FAIL ba_write_count: got %0d expected 3", wrCount - w0); end
`endif
    checks++;
    if (wrPeriods.size() < 3 || wrPeriods[1] - wrPeriods[0] != 3 || wrPeriods[2] - wrPeriods[1] != 1) begin
      failures++; $display("[TB] FAIL ba_hold_cycles: got %0d writes with wrong spacing, expected gap of 2 held cycles", wrPeriods.size());
    end
    expQ.delete();
  endtask

  task automatic test_wrap();
    int d0;
    bit ok;
    setImage(8'hFF, 8'hFF, 8'h11, 8'h22, 8'h00);
    expQ.push_back({16'hFFFF, 8'h11});
    expQ.push_back({16'h0000, 8'h22});
`ifdef PRG_DMA_LOADER_BASIC_PATCH_EN
    expQ.push_back({16'h002D, 8'h01});
    expQ.push_back({16'h002E, 8'h00});
`endif
    d0 = doneCount;
    pulseStart(16'd4);
    waitDone(d0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL wrap_done: got timeout expected done"); end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL wrap_missing_writes: got %0d left expected 0", expQ.size()); end
    expQ.delete();
  endtask

  task automatic test_short();
    int e0;
    e0 = errorCount;
    dmaSeen = 1'b0;
    pulseStart(16'd2);
    @(negedge clk);
    checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL short_error_pulse: got %b expected 1", error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL short_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL short_error_width: got %b expected 0", error); end
    repeat (40) @(negedge clk);
    checks++; if (dmaSeen !== 1'b0) begin failures++; $display("[TB] FAIL short_dma: got DMA asserted expected never"); end
    checks++; if (errorCount - e0 != 1) begin failures++; $display("[TB] FAIL short_error_count: got %0d expected 1", errorCount - e0); end
  endtask

  task automatic test_reset_mid();
    int w0, w1;
    bit ok;
    setImage(8'h01, 8'h08, 8'hAA, 8'hBB, 8'hCC);
    expQ.push_back({16'h0801, 8'hAA});
    expQ.push_back({16'h0802, 8'hBB});
    w0 = wrCount;
    pulseStart(16'd5);
    waitWrites(w0 + 2, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_mid_writes: got timeout expected 2 writes"); end
    checks++; if (DMA !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_dma_before: got %b expected 1", DMA); end
    #2 reset = 1'b0;
    #0.2;
    checks++; if ({DMA, RW} !== 2'b01) begin failures++; $display("[TB] FAIL rst_mid_async: got DMA,RW=%b expected 01", {DMA, RW}); end
    checks++; if ({busy, Ai} !== 17'h0_0000) begin failures++; $display("[TB] FAIL rst_mid_values: got busy=%b Ai=%h expected 0 0000", busy, Ai); end
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    w1 = wrCount;
    repeat (12) @(negedge phi2);
    @(negedge clk);
    checks++; if (wrCount != w1) begin failures++; $display("[TB] FAIL rst_mid_resume: got %0d writes after reset expected 0", wrCount - w1); end
    checks++; if ({DMA, busy} !== 2'b00) begin failures++; $display("[TB] FAIL rst_mid_idle: got DMA,busy=%b expected 00", {DMA, busy}); end
    expQ.delete();
  endtask

  initial begin
    $display("[TB] prg_dma_loader bench start");
    test_reset();
    test_nominal();
    test_ba_low();
    test_wrap();
    test_short();
    test_reset_mid();
    test_nominal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
